// File: rtl/regbank32.sv
// 32-entry x N-bit register bank with one-hot write decode and a sequential clear engine.
// Optional build macro: REGBANK32_ZERO_REG_EN hardwires entry 0 to zero.
module regbank32 #(
    parameter int N = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         wr_valid,
    output logic         wr_ready,
    input  logic [4:0]   wr_addr,
    input  logic [N-1:0] wr_data,
    output logic         wr_ack,
    input  logic         clr_req,
    output logic         busy,
    output logic [N-1:0] q0,
    output logic [N-1:0] q1,
    output logic [N-1:0] q2,
    output logic [N-1:0] q3,
    output logic [N-1:0] q4,
    output logic [N-1:0] q5,
    output logic [N-1:0] q6,
    output logic [N-1:0] q7,
    output logic [N-1:0] q8,
    output logic [N-1:0] q9,
    output logic [N-1:0] q10,
    output logic [N-1:0] q11,
    output logic [N-1:0] q12,
    output logic [N-1:0] q13,
    output logic [N-1:0] q14,
    output logic [N-1:0] q15,
    output logic [N-1:0] q16,
    output logic [N-1:0] q17,
    output logic [N-1:0] q18,
    output logic [N-1:0] q19,
    output logic [N-1:0] q20,
    output logic [N-1:0] q21,
    output logic [N-1:0] q22,
    output logic [N-1:0] q23,
    output logic [N-1:0] q24,
    output logic [N-1:0] q25,
    output logic [N-1:0] q26,
    output logic [N-1:0] q27,
    output logic [N-1:0] q28,
    output logic [N-1:0] q29,
    output logic [N-1:0] q30,
    output logic [N-1:0] q31
);

    // Handshake: a write is taken on any rising edge where wr_valid && wr_ready;
    // the requester holds wr_addr/wr_data stable until then, and wr_ack follows one cycle later.

    typedef enum logic {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } state_t;

    state_t       state;
    state_t       state_nxt;
    logic [4:0]   ccnt;
    logic [4:0]   ccnt_nxt;
    logic         wr_en;
    logic [N-1:0] mem [32];

    always_comb begin
        state_nxt = state;
        ccnt_nxt  = ccnt;
        case (state)
            IDLE: begin
                if (clr_req) begin
                    state_nxt = CLEAR;
                    ccnt_nxt  = 5'd0;
                end
            end
            CLEAR: begin
                ccnt_nxt = ccnt + 5'd1;
                if (ccnt == 5'd31) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
                ccnt_nxt  = 5'd0;
            end
        endcase
    end

    assign wr_ready = (state == IDLE);
    assign wr_en    = wr_valid && wr_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            ccnt   <= 5'd0;
            busy   <= 1'b0;
            wr_ack <= 1'b0;
        end else begin
            state  <= state_nxt;
            ccnt   <= ccnt_nxt;
            busy   <= (state_nxt == CLEAR);
            wr_ack <= wr_en;
        end
    end

    // Clearing and writing never coincide: writes are only taken in IDLE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 32; i++) begin
                mem[i] <= '0;
            end
        end else if (state == CLEAR) begin
            mem[ccnt] <= '0;
        end else if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

`ifdef REGBANK32_ZERO_REG_EN
    assign q0 = '0;
`else
    assign q0 = mem[0];
`endif
    assign q1  = mem[1];
    assign q2  = mem[2];
    assign q3  = mem[3];
    assign q4  = mem[4];
    assign q5  = mem[5];
    assign q6  = mem[6];
    assign q7  = mem[7];
    assign q8  = mem[8];
    assign q9  = mem[9];
    assign q10 = mem[10];
    assign q11 = mem[11];
    assign q12 = mem[12];
    assign q13 = mem[13];
    assign q14 = mem[14];
    assign q15 = mem[15];
    assign q16 = mem[16];
    assign q17 = mem[17];
    assign q18 = mem[18];
    assign q19 = mem[19];
    assign q20 = mem[20];
    assign q21 = mem[21];
    assign q22 = mem[22];
    assign q23 = mem[23];
    assign q24 = mem[24];
    assign q25 = mem[25];
    assign q26 = mem[26];
    assign q27 = mem[27];
    assign q28 = mem[28];
    assign q29 = mem[29];
    assign q30 = mem[30];
    assign q31 = mem[31];

endmodule

// File: tb/tb_regbank32.sv
// Randomized bench for regbank32 against an edge-counting reference model.
// Honours REGBANK32_ZERO_REG_EN when it is defined for the build.
module tb_regbank32;

`ifdef REGBANK32_ZERO_REG_EN
    localparam bit ZERO_REG = 1'b1;
`else
    localparam bit ZERO_REG = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic        wr_valid;
    logic        wr_ready;
    logic [4:0]  wr_addr;
    logic [31:0] wr_data;
    logic        wr_ack;
    logic        clr_req;
    logic        busy;
    logic [31:0] qv [32];

    int          asrt_cnt = 0;
    int          fail_cnt = 0;

    // Reference model: entry contents plus the edge window of the current clear.
    logic [31:0] model [32];
    int          edge_no   = 0;
    int          clr_start = -100;
    int          clr_end   = 0;
    logic [36:0] exp_q [$];

    always #5 clk = ~clk;

    regbank32 #(.N(32)) dut (
        .clk(clk), .rst_n(rst_n), .wr_valid(wr_valid), .wr_ready(wr_ready),
        .wr_addr(wr_addr), .wr_data(wr_data), .wr_ack(wr_ack), .clr_req(clr_req), .busy(busy),
        .q0(qv[0]),   .q1(qv[1]),   .q2(qv[2]),   .q3(qv[3]),
        .q4(qv[4]),   .q5(qv[5]),   .q6(qv[6]),   .q7(qv[7]),
        .q8(qv[8]),   .q9(qv[9]),   .q10(qv[10]), .q11(qv[11]),
        .q12(qv[12]), .q13(qv[13]), .q14(qv[14]), .q15(qv[15]),
        .q16(qv[16]), .q17(qv[17]), .q18(qv[18]), .q19(qv[19]),
        .q20(qv[20]), .q21(qv[21]), .q22(qv[22]), .q23(qv[23]),
        .q24(qv[24]), .q25(qv[25]), .q26(qv[26]), .q27(qv[27]),
        .q28(qv[28]), .q29(qv[29]), .q30(qv[30]), .q31(qv[31])
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        asrt_cnt++;
        if (got !== exp) begin
            fail_cnt++;
            $display("FAIL %s: got=%0h expected=%0h (edge %0d)", tag, got, exp, edge_no);
        end
    endtask

    task automatic check_reset_state();
        for (int k = 0; k < 32; k++) begin
            chk($sformatf("rst_q%0d", k), 64'(qv[k]), 64'd0);
        end
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_wr_ready", 64'(wr_ready), 64'd1);
        chk("rst_wr_ack", 64'(wr_ack), 64'd0);
    endtask

    // One clock edge: update the model from the inputs presented, then compare everything.
    task automatic tick();
        logic        acc;
        logic        st;
        logic [4:0]  a;
        logic [31:0] d;
        logic [36:0] e;
        acc = wr_valid && (edge_no >= clr_end);
        st  = clr_req && (edge_no >= clr_end);
        a   = wr_addr;
        d   = wr_data;
        @(posedge clk);
        edge_no++;
        if (edge_no > clr_start && edge_no <= clr_end) begin
            model[edge_no - clr_start - 1] = '0;
        end
        if (acc) begin
            if (!(ZERO_REG && a == 5'd0)) begin
                model[a] = d;
            end
            exp_q.push_back({a, d});
        end
        if (st) begin
            clr_start = edge_no;
            clr_end   = edge_no + 32;
        end
        #1;
        chk("wr_ack", 64'(wr_ack), 64'(acc));
        chk("busy", 64'(busy), 64'(edge_no < clr_end));
        chk("wr_ready", 64'(wr_ready), 64'(edge_no >= clr_end));
        for (int k = 0; k < 32; k++) begin
            chk($sformatf("q%0d", k), 64'(qv[k]), 64'(model[k]));
        end
        if (wr_ack) begin
            if (exp_q.size() == 0) begin
                chk("ack_without_write", 64'd1, 64'd0);
            end else begin
                e = exp_q.pop_front();
                chk("ack_data", 64'(qv[e[36:32]]),
                    (ZERO_REG && e[36:32] == 5'd0) ? 64'd0 : 64'(e[31:0]));
            end
        end
        @(negedge clk);
    endtask

    task automatic do_reset();
        wr_valid = 1'b0;
        clr_req  = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        for (int k = 0; k < 32; k++) model[k] = '0;
        clr_start = -100;
        clr_end   = edge_no;
        exp_q.delete();
        check_reset_state();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic do_write(input logic [4:0] a, input logic [31:0] d);
        logic taken;
        taken    = 1'b0;
        wr_valid = 1'b1;
        wr_addr  = a;
        wr_data  = d;
        for (int n = 0; n < 100 && !taken; n++) begin
            taken = (edge_no >= clr_end);
            tick();
        end
        if (!taken) chk("write_timeout", 64'd0, 64'd1);
        wr_valid = 1'b0;
    endtask

    task automatic sweep(input logic [31:0] base, input logic add_k);
        for (int k = 0; k < 32; k++) begin
            wr_valid = 1'b1;
            wr_addr  = 5'(k);
            wr_data  = add_k ? base + 32'(k) : base;
            tick();
        end
        wr_valid = 1'b0;
    endtask

    initial begin
        rst_n    = 1'b0;
        wr_valid = 1'b0;
        wr_addr  = '0;
        wr_data  = '0;
        clr_req  = 1'b0;
        for (int k = 0; k < 32; k++) model[k] = '0;
        #1;
        check_reset_state();
        @(negedge clk);
        rst_n = 1'b1;

        sweep(32'hA500_0000, 1'b1);
        tick();

        for (int i = 0; i < 60; i++) begin
            wr_valid = 1'($urandom_range(0, 1));
            wr_addr  = 5'($urandom_range(0, 31));
            wr_data  = $urandom;
            tick();
        end
        wr_valid = 1'b0;

        sweep(32'hA500_0000, 1'b1);
        do_reset();

        sweep(32'hFFFF_FFFF, 1'b0);
        clr_req = 1'b1;
        tick();
        clr_req = 1'b0;
        tick();
        do_write(5'd7, 32'h1234);
        chk("stall_q7", 64'(qv[7]), 64'h1234);
        tick();

        wr_valid = 1'b1;
        wr_addr  = 5'd31;
        wr_data  = 32'hDEAD;
        clr_req  = 1'b1;
        tick();
        wr_valid = 1'b0;
        clr_req  = 1'b0;
        chk("simul_q31_written", 64'(qv[31]), 64'hDEAD);
        repeat (33) tick();
        chk("simul_q31_cleared", 64'(qv[31]), 64'd0);

        do_write(5'd0, 32'h55);
        chk("addr0_q0", 64'(qv[0]), ZERO_REG ? 64'd0 : 64'h55);

        for (int i = 0; i < 300; i++) begin
            wr_valid = 1'($urandom_range(0, 1));
            wr_addr  = 5'($urandom_range(0, 31));
            wr_data  = $urandom;
            clr_req  = ($urandom_range(0, 15) == 0);
            tick();
        end
        wr_valid = 1'b0;
        clr_req  = 1'b0;

        sweep(32'h0BAD_0000, 1'b1);
        clr_req = 1'b1;
        tick();
        clr_req = 1'b0;
        repeat (5) tick();
        do_reset();
        do_write(5'd3, 32'hCAFE);
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", asrt_cnt, fail_cnt);
        $finish;
    end

endmodule
